rtc_access_scheduler: RTL and testbench
=======================================

Name: rtc_access_scheduler

Overview:
- Sequences all traffic to the shared RTC parallel-bus transaction engine.
- Periodically sweeps the nine time/timer registers into a coherent shadow register file, so display logic never touches the bus.
- Arbitrates user/host register writes against the refresh sweep.
- Sits between the PicoBlaze-side control logic and the RTC bus engine; it is the engine's only master.

Parameters:
- REFRESH_CYCLES, 10000000: clk cycles between sweep triggers (100 ms at 100 MHz); minimum 16.
- TIMEOUT_CYCLES, 1023: maximum cycles to wait for bus_done before aborting a transaction.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- wr_req  in  1  host write request, held high until wr_ack
- wr_addr  in  8  RTC register address, stable while wr_req is high
- wr_data  in  8  write data, stable while wr_req is high
- wr_ack  out  1  one-cycle pulse: host write finished
- wr_err  out  1  valid with wr_ack: the write timed out
- sh_idx  in  4  shadow read index 0..8
- sh_data  out  8  shadow byte, registered, 1-cycle latency
- snap_valid  out  1  one-cycle pulse: new coherent snapshot committed
- bus_req  out  1  transaction request to the bus engine
- bus_wr  out  1  1 = write, 0 = read
- bus_addr  out  8  transaction address
- bus_wdata  out  8  transaction write data
- bus_rdata  in  8  read data, valid when bus_done = 1
- bus_done  in  1  one-cycle completion pulse from the engine
- bus_err  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- Reset: all outputs 0, shadow and staging registers 0, refresh counter loaded with REFRESH_CYCLES-1, sweep_pending = 0, wr_armed = 1, state IDLE. Reset mid-transaction drops bus_req in the next cycle.
- Sweep table, index to address:
  - 0..5 map to 0x21..0x26 (sec, min, hour, day, month, year).
  - 6..8 map to 0x41..0x43 (timer hour, min, sec).
- Refresh counter:
  - Free-running; decrements every cycle, including during sweeps.
  - On reaching 0: set sweep_pending and reload.
  - Expiry while sweep_pending is already 1 has no further effect.
- Write acceptance:
  - A write is accepted only when wr_req = 1 and wr_armed = 1.
  - wr_armed clears when wr_ack pulses and sets again after wr_req is sampled 0 (4-phase handshake).
  - wr_addr and wr_data are captured on acceptance.
- Bus handshake:
  - bus_req rises with bus_addr, bus_wr and bus_wdata valid, and they are held stable until bus_done is sampled high.
  - bus_req drops in the cycle after bus_done.
  - At most one transaction is outstanding.
  - bus_done while bus_req = 0 is ignored.
- FSM states: IDLE, WR_ISSUE, WR_WAIT, WR_ACK, RD_ISSUE, RD_WAIT, COMMIT.
  - IDLE: an accepted write goes to WR_ISSUE (writes have priority). Otherwise, if sweep_pending, go to RD_ISSUE with idx = 0 and clear sweep_pending.
  - WR_ISSUE: assert bus_req with bus_wr = 1, then go to WR_WAIT.
  - WR_WAIT: on bus_done go to WR_ACK. On timeout go to WR_ACK with wr_err = 1 and set bus_err.
  - WR_ACK: pulse wr_ack for 1 cycle, then go to IDLE.
  - RD_ISSUE: assert bus_req with bus_wr = 0 and bus_addr = table[idx], then go to RD_WAIT.
  - RD_WAIT: on bus_done, staging[idx] <= bus_rdata.
    - idx = 8: go to COMMIT.
    - Pending accepted write: abort the sweep, set sweep_pending = 1, go to WR_ISSUE. The sweep later restarts from idx 0.
    - Otherwise idx++ and go to RD_ISSUE.
    - On timeout: set bus_err, discard staging, clear idx, go to IDLE. No commit; the next trigger retries.
  - COMMIT: copy all 9 staging bytes to shadow in a single cycle, pulse snap_valid, then go to IDLE.
- The timeout counter resets on every issue. Timeout fires when bus_done has not been seen after TIMEOUT_CYCLES cycles in a WAIT state.
- Shadow is updated only in COMMIT, so readers never see a mixed snapshot.
- sh_data <= shadow[sh_idx]. For sh_idx > 8, sh_data <= 0.
- Write to an address in the sweep table: the new value appears in shadow only after the next completed sweep.

Test Plan:
- Reset, then idle for REFRESH_CYCLES (set to 64): expect 9 reads at 0x21..0x26 and 0x41..0x43 in order. Engine returns 0x10+idx; expect snap_valid pulse, and sh_idx = 3 gives sh_data = 0x13 one cycle later.
- wr_req with addr 0x22, data 0x45 while idle: expect one bus write (bus_wr = 1, 0x22, 0x45), then wr_ack pulse with wr_err = 0. wr_req held high afterwards must not produce a second write until it drops.
- Write raised during sweep read idx 4: read 4 completes, then the write is issued. The sweep restarts at 0x21 with 9 fresh reads, and only one snap_valid is produced.
- Engine never answers a read: after TIMEOUT_CYCLES bus_req drops and bus_err = 1. There is no snap_valid, and the shadow keeps its prior values.
- Engine never answers a write: wr_ack = 1 with wr_err = 1, and bus_err stays set until reset.
- Reset asserted during RD_WAIT: bus_req = 0 next cycle and shadow = 0. The next sweep occurs REFRESH_CYCLES after reset release.

Source files
------------

// File: rtl/rtc_access_scheduler.sv
// Sole master of the RTC bus engine: periodic 9-register sweep into a
// coherent shadow file, arbitrated against 4-phase host register writes.
module rtc_access_scheduler #(
   parameter int REFRESH_CYCLES = 10000000,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_req,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ack,
   output logic       wr_err,
   input  logic [3:0] sh_idx,
   output logic [7:0] sh_data,
   output logic       snap_valid,
   output logic       bus_req,
   output logic       bus_wr,
   output logic [7:0] bus_addr,
   output logic [7:0] bus_wdata,
   input  logic [7:0] bus_rdata,
   input  logic       bus_done,
   output logic       bus_err
);

   localparam int RCW = $clog2(REFRESH_CYCLES);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [RCW-1:0] RLOAD = RCW'(REFRESH_CYCLES - 1);
   localparam logic [TCW-1:0] TLAST = TCW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, WR_ISSUE, WR_WAIT, WR_ACK, RD_ISSUE, RD_WAIT, COMMIT
   } state_t;

   state_t           state_q, state_d;
   logic [RCW-1:0]   rcnt_q, rcnt_d;
   logic [TCW-1:0]   tcnt_q, tcnt_d;
   logic             sweep_pend_q, sweep_pend_d;
   logic             wr_armed_q, wr_armed_d;
   logic             wr_pend_q, wr_pend_d;
   logic [7:0]       wa_q, wa_d;
   logic [7:0]       wd_q, wd_d;
   logic             werr_q, werr_d;
   logic [3:0]       idx_q, idx_d;
   logic [8:0][7:0]  staging_q, staging_d;
   logic [8:0][7:0]  shadow_q, shadow_d;
   logic [7:0]       sh_data_q, sh_data_d;
   logic             bus_req_q, bus_req_d;
   logic             bus_wr_q, bus_wr_d;
   logic [7:0]       bus_addr_q, bus_addr_d;
   logic [7:0]       bus_wdata_q, bus_wdata_d;
   logic             bus_err_q, bus_err_d;

   logic acc, wpend, done, tmo, rexp;

   function automatic logic [7:0] tbl(input logic [3:0] i);
      if (i < 4'd6) return 8'h21 + {4'h0, i};
      else          return 8'h3B + {4'h0, i};
   endfunction

   always_comb begin
      state_d      = state_q;
      tcnt_d       = tcnt_q;
      sweep_pend_d = sweep_pend_q;
      wr_armed_d   = wr_armed_q;
      wr_pend_d    = wr_pend_q;
      wa_d         = wa_q;
      wd_d         = wd_q;
      werr_d       = werr_q;
      idx_d        = idx_q;
      staging_d    = staging_q;
      shadow_d     = shadow_q;
      bus_req_d    = bus_req_q;
      bus_wr_d     = bus_wr_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      bus_err_d    = bus_err_q;

      rexp   = (rcnt_q == '0);
      rcnt_d = rexp ? RLOAD : rcnt_q - 1'b1;
      if (rexp) sweep_pend_d = 1'b1;

      // A write stays latched in wr_pend until its ack, even across a sweep
      acc   = wr_req & wr_armed_q & ~wr_pend_q;
      wpend = wr_pend_q | acc;
      if (acc) begin
         wr_pend_d = 1'b1;
         wa_d      = wr_addr;
         wd_d      = wr_data;
      end
      if (!wr_req) wr_armed_d = 1'b1;

      done = bus_done & bus_req_q;
      tmo  = (tcnt_q == TLAST);

      sh_data_d = (sh_idx <= 4'd8) ? shadow_q[sh_idx] : 8'h00;

      unique case (state_q)
         IDLE: begin
            if (wpend) begin
               state_d = WR_ISSUE;
            end else if (sweep_pend_q) begin
               state_d      = RD_ISSUE;
               idx_d        = 4'd0;
               sweep_pend_d = 1'b0;
            end
         end
         WR_ISSUE: begin
            bus_req_d   = 1'b1;
            bus_wr_d    = 1'b1;
            bus_addr_d  = wa_q;
            bus_wdata_d = wd_q;
            tcnt_d      = '0;
            state_d     = WR_WAIT;
         end
         WR_WAIT: begin
            if (done) begin
               bus_req_d = 1'b0;
               werr_d    = 1'b0;
               state_d   = WR_ACK;
            end else if (tmo) begin
               bus_req_d = 1'b0;
               werr_d    = 1'b1;
               bus_err_d = 1'b1;
               state_d   = WR_ACK;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         WR_ACK: begin
            wr_armed_d = 1'b0;
            wr_pend_d  = 1'b0;
            state_d    = IDLE;
         end
         RD_ISSUE: begin
            bus_req_d   = 1'b1;
            bus_wr_d    = 1'b0;
            bus_addr_d  = tbl(idx_q);
            bus_wdata_d = 8'h00;
            tcnt_d      = '0;
            state_d     = RD_WAIT;
         end
         RD_WAIT: begin
            if (done) begin
               bus_req_d          = 1'b0;
               staging_d[idx_q]   = bus_rdata;
               if (idx_q == 4'd8) begin
                  state_d = COMMIT;
               end else if (wpend) begin
                  // Abandon this sweep; it restarts from index 0 later
                  sweep_pend_d = 1'b1;
                  idx_d        = 4'd0;
                  state_d      = WR_ISSUE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = RD_ISSUE;
               end
            end else if (tmo) begin
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
               staging_d = '0;
               idx_d     = 4'd0;
               state_d   = IDLE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         COMMIT: begin
            shadow_d = staging_q;
            idx_d    = 4'd0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         rcnt_q       <= RLOAD;
         tcnt_q       <= '0;
         sweep_pend_q <= 1'b0;
         wr_armed_q   <= 1'b1;
         wr_pend_q    <= 1'b0;
         wa_q         <= 8'h00;
         wd_q         <= 8'h00;
         werr_q       <= 1'b0;
         idx_q        <= 4'd0;
         staging_q    <= '0;
         shadow_q     <= '0;
         sh_data_q    <= 8'h00;
         bus_req_q    <= 1'b0;
         bus_wr_q     <= 1'b0;
         bus_addr_q   <= 8'h00;
         bus_wdata_q  <= 8'h00;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rcnt_q       <= rcnt_d;
         tcnt_q       <= tcnt_d;
         sweep_pend_q <= sweep_pend_d;
         wr_armed_q   <= wr_armed_d;
         wr_pend_q    <= wr_pend_d;
         wa_q         <= wa_d;
         wd_q         <= wd_d;
         werr_q       <= werr_d;
         idx_q        <= idx_d;
         staging_q    <= staging_d;
         shadow_q     <= shadow_d;
         sh_data_q    <= sh_data_d;
         bus_req_q    <= bus_req_d;
         bus_wr_q     <= bus_wr_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign wr_ack     = (state_q == WR_ACK);
   assign wr_err     = (state_q == WR_ACK) & werr_q;
   assign snap_valid = (state_q == COMMIT);
   assign sh_data    = sh_data_q;
   assign bus_req    = bus_req_q;
   assign bus_wr     = bus_wr_q;
   assign bus_addr   = bus_addr_q;
   assign bus_wdata  = bus_wdata_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Scoreboard bench for rtc_access_scheduler: expected bus/ack/snapshot
// events are queued by the stimulus and checked by an independent monitor.
module tb_rtc_access_scheduler;

   localparam int R = 64;
   localparam int T = 20;

   localparam logic [1:0] EV_BUS  = 2'd0;
   localparam logic [1:0] EV_ACK  = 2'd1;
   localparam logic [1:0] EV_SNAP = 2'd2;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_req;
   logic [7:0] wr_addr, wr_data;
   logic       wr_ack, wr_err;
   logic [3:0] sh_idx;
   logic [7:0] sh_data;
   logic       snap_valid;
   logic       bus_req, bus_wr;
   logic [7:0] bus_addr, bus_wdata, bus_rdata;
   logic       bus_done;
   logic       bus_err;

   logic       mute;
   logic [7:0] rbase;

   typedef struct packed {
      logic [1:0] kind;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
   } ev_t;

   ev_t q[$];
   int  n_chk  = 0;
   int  n_pass = 0;

   rtc_access_scheduler #(.REFRESH_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .wr_err(wr_err),
      .sh_idx(sh_idx), .sh_data(sh_data), .snap_valid(snap_valid),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_done(bus_done),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, got, exp);
   endtask

   function automatic logic [7:0] tbl(input int i);
      return (i < 6) ? 8'(8'h21 + i) : 8'(8'h41 + i - 6);
   endfunction

   function automatic logic [7:0] idx_of(input logic [7:0] a);
      return (a < 8'h40) ? 8'(a - 8'h21) : 8'(a - 8'h41 + 8'd6);
   endfunction

   task automatic push_rd(input logic [7:0] a);
      q.push_back('{kind: EV_BUS, wr: 1'b0, addr: a, data: 8'h00});
   endtask

   task automatic push_sweep();
      for (int i = 0; i < 9; i++) push_rd(tbl(i));
      q.push_back('{kind: EV_SNAP, wr: 1'b0, addr: 8'h00, data: 8'h00});
   endtask

   task automatic push_wr(input logic [7:0] a, input logic [7:0] d,
                          input logic err);
      q.push_back('{kind: EV_BUS, wr: 1'b1, addr: a, data: d});
      q.push_back('{kind: EV_ACK, wr: 1'b0, addr: 8'h00, data: {7'd0, err}});
   endtask

   task automatic pop_cmp(input logic [1:0] kind, input logic wr,
                          input logic [7:0] a, input logic [7:0] d);
      ev_t e;
      chk("event_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("ev_kind", kind, e.kind);
         if (kind == EV_BUS && e.kind == EV_BUS) begin
            chk("bus_wr", wr, e.wr);
            chk("bus_addr", a, e.addr);
            if (e.wr) chk("bus_wdata", d, e.data);
         end
         if (kind == EV_ACK && e.kind == EV_ACK) chk("wr_err", d, e.data);
      end
   endtask

   // Monitor
   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_req && !prev) pop_cmp(EV_BUS, bus_wr, bus_addr, bus_wdata);
         if (wr_ack) pop_cmp(EV_ACK, 1'b0, 8'h00, {7'd0, wr_err});
         if (snap_valid) pop_cmp(EV_SNAP, 1'b0, 8'h00, 8'h00);
         prev = bus_req;
      end
   end

   // Bus engine: answers one cycle after bus_req rises unless muted
   initial begin
      bus_done  = 1'b0;
      bus_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (!mute && bus_req && !bus_done) begin
            bus_done  = 1'b1;
            bus_rdata = rbase + idx_of(bus_addr);
         end else begin
            bus_done = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic drain(input string nm, input int n);
      for (int i = 0; i < n; i++) begin
         if (q.size() == 0) break;
         @(negedge clk);
      end
      chk(nm, q.size(), 0);
   endtask

   task automatic wait_ack(input string nm, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (wr_ack) break;
      end
      chk(nm, wr_ack, 1);
   endtask

   task automatic wait_req(input string nm, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus_req) break;
      end
      chk(nm, bus_req, 1);
   endtask

   task automatic sh_rd(input string nm, input logic [3:0] i,
                        input logic [7:0] exp);
      sh_idx = i;
      @(negedge clk);
      chk(nm, sh_data, exp);
   endtask

   initial begin
      int hi, cyc;
      reset = 1'b1; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
      sh_idx = 4'd0; mute = 1'b0; rbase = 8'h10;
      repeat (3) @(negedge clk);
      chk("rst_bus_req", bus_req, 0);
      chk("rst_wr_ack", wr_ack, 0);
      chk("rst_wr_err", wr_err, 0);
      chk("rst_snap", snap_valid, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_sh_data", sh_data, 0);

      // First periodic sweep
      push_sweep();
      reset = 1'b0;
      drain("p1_drain", 150);
      repeat (2) @(negedge clk);
      sh_rd("p1_sh3", 4'd3, 8'h13);
      sh_rd("p1_sh8", 4'd8, 8'h18);
      sh_rd("p1_sh9", 4'd9, 8'h00);
      sh_rd("p1_sh15", 4'd15, 8'h00);

      // Idle write; held request must not retrigger
      push_wr(8'h22, 8'h45, 1'b0);
      wr_addr = 8'h22; wr_data = 8'h45; wr_req = 1'b1;
      wait_ack("p2_ack", 30);
      repeat (6) @(negedge clk);
      wr_req = 1'b0;
      @(negedge clk);
      drain("p2_drain", 10);
      chk("p2_bus_err", bus_err, 0);

      // Write arriving during read of index 4 aborts and restarts sweep
      rbase = 8'h50;
      for (int i = 0; i < 5; i++) push_rd(tbl(i));
      push_wr(8'h43, 8'h99, 1'b0);
      push_sweep();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus_req && bus_addr == 8'h25) break;
      end
      chk("p3_idx4_seen", bus_addr, 8'h25);
      wr_addr = 8'h43; wr_data = 8'h99; wr_req = 1'b1;
      wait_ack("p3_ack", 40);
      wr_req = 1'b0;
      drain("p3_drain", 100);
      repeat (2) @(negedge clk);
      sh_rd("p3_sh4", 4'd4, 8'h54);
      sh_rd("p3_sh8", 4'd8, 8'h58);

      // Read timeout
      mute = 1'b1;
      push_rd(8'h21);
      wait_req("p4_req", 100);
      hi = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus_req) hi++;
         else break;
      end
      chk("p4_req_cycles", hi, T);
      chk("p4_bus_err", bus_err, 1);
      chk("p4_req_low", bus_req, 0);
      sh_rd("p4_sh4_kept", 4'd4, 8'h54);
      sh_rd("p4_sh0_kept", 4'd0, 8'h50);

      // Write timeout
      push_wr(8'h30, 8'h01, 1'b1);
      wr_addr = 8'h30; wr_data = 8'h01; wr_req = 1'b1;
      wait_ack("p5_ack", 40);
      wr_req = 1'b0;
      repeat (5) @(negedge clk);
      chk("p5_bus_err_sticky", bus_err, 1);

      // Reset in RD_WAIT
      push_rd(8'h21);
      wait_req("p6_req", 60);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("p6_req_dropped", bus_req, 0);
      chk("p6_bus_err_clr", bus_err, 0);
      @(negedge clk);
      rbase = 8'h70;
      mute  = 1'b0;
      push_sweep();
      sh_idx = 4'd4;
      reset  = 1'b0;
      cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         cyc++;
         if (cyc == 3) chk("p6_shadow_cleared", sh_data, 0);
         if (bus_req) break;
      end
      // trigger at R cycles, then IDLE->RD_ISSUE->bus_req
      chk("p6_first_req_cycle", cyc, R + 2);
      drain("p6_drain", 60);
      repeat (2) @(negedge clk);
      sh_rd("p6_sh0", 4'd0, 8'h70);
      sh_rd("p6_sh8", 4'd8, 8'h78);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
